// File: rtl/mul_sequencer_pkg.sv
// Shared EX-stage definitions for the iterative multiplier: optype codes,
// default datapath width and sequencer state encoding.
package mul_sequencer_pkg;

    localparam int unsigned MUL_XLEN = 32;

    typedef enum logic {
        OPT_MUL  = 1'b0,
        OPT_MULH = 1'b1
    } ex_optype_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    // EX decode helper: MULH selects the high half of the signed product.
    function automatic logic optype_is_high(input ex_optype_e op);
        return op == OPT_MULH;
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the EX-stage decode and the multiply sequencer.
interface mul_sequencer_if #(
    parameter int unsigned XLEN = mul_sequencer_pkg::MUL_XLEN
);
    logic            start;
    logic            op_high;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op_high, src_a, src_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, op_high, src_a, src_b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/mul_sequencer_mul_step.sv
// One sequencer iteration: adds the shifted multiplicand into the accumulator
// for each set bit of the current multiplier slice.
module mul_step #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned POS_W          = 5
) (
    input  logic [2*XLEN-1:0]         acc_i,
    input  logic [XLEN-1:0]           mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] slice_i,
    input  logic [POS_W-1:0]          pos_i,
    output logic [2*XLEN-1:0]         acc_o
);

    logic [2*XLEN-1:0] mcand_w;

    always_comb begin
        acc_o   = acc_i;
        mcand_w = {{XLEN{1'b0}}, mcand_i} << pos_i;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (slice_i[i]) begin
                acc_o = acc_o + (mcand_w << i);
            end
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative signed shift-add multiplier controller for the EX stage; stalls the
// front end while busy and returns MUL/MULH results with a one-cycle done strobe.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int unsigned XLEN           = MUL_XLEN,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst,
    mul_sequencer_if.slave bus
);

    localparam int unsigned STEPS = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned POS_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic              high_q, high_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod;
    logic [POS_W-1:0]  bit_pos;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

    assign bit_pos = POS_W'(cnt_q) * POS_W'(BITS_PER_CYCLE);

    mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .POS_W          (POS_W)
    ) u_mul_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .pos_i   (bit_pos),
        .acc_o   (step_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            high_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            high_q   <= high_d;
            result_q <= result_d;
        end
    end

    // Sign fix-up is applied to the final accumulator value so result can be
    // registered on the same edge that enters DONE.
    always_comb begin
        prod = step_acc;
        if (neg_q) begin
            prod = '0 - step_acc;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        high_d   = high_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d  = S_BUSY;
                    mcand_d  = magnitude(bus.src_a);
                    mplier_d = magnitude(bus.src_b);
                    neg_d    = bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1];
                    high_d   = bus.op_high;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = step_acc;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d  = S_DONE;
                        result_d = high_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.stall  = (state_q == S_BUSY) ||
                     ((state_q == S_IDLE) && bus.start && !bus.flush);
        bus.busy   = (state_q != S_IDLE);
        bus.done   = (state_q == S_DONE) && !bus.flush;
        bus.result = result_q;
    end

endmodule
